// File: rtl/icache_pkg.sv
// icache_pkg: shared types and width helpers for the direct-mapped icache.
//   state_e      : controller states (IDLE / REFILL / RESP)
//   DEF_LINES    : default number of cache lines
//   DEF_WORDS    : default 32-bit words per line
//   offset_w/index_w/tag_w : address field widths for a given geometry
package icache_pkg;

  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  function automatic int offset_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  // Word-aligned byte address: two low bits never reach the tag.
  function automatic int tag_w(input int lines, input int words);
    return 32 - 2 - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays for the direct-mapped icache.
//   clk, reset          : clock, async active-high reset (clears everything)
//   flush_all_i         : invalidate every line
//   rd_index_i          : combinational lookup index
//   rd_valid_o/rd_tag_o/rd_data_o : line state at rd_index_i
//   wr_en_i, wr_index_i, wr_word_i, wr_data_i : single-word refill write
//   install_i, install_tag_i : mark line wr_index_i valid with the given tag
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int IW    = index_w(LINES),
  parameter int OW    = offset_w(WORDS),
  parameter int TW    = tag_w(LINES, WORDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_all_i,
  input  logic [IW-1:0]           rd_index_i,
  output logic                    rd_valid_o,
  output logic [TW-1:0]           rd_tag_o,
  output logic [WORDS-1:0][31:0]  rd_data_o,
  input  logic                    wr_en_i,
  input  logic [IW-1:0]           wr_index_i,
  input  logic [OW-1:0]           wr_word_i,
  input  logic [31:0]             wr_data_i,
  input  logic                    install_i,
  input  logic [TW-1:0]           install_tag_i
);

  logic [LINES-1:0]                   valid_q;
  logic [LINES-1:0][TW-1:0]           tag_q;
  logic [LINES-1:0][WORDS-1:0][31:0]  data_q;

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (wr_en_i) data_q[wr_index_i][wr_word_i] <= wr_data_i;
      if (install_i) tag_q[wr_index_i] <= install_tag_i;
      // Flush and install never coincide: flush is only applied in IDLE.
      if (flush_all_i)    valid_q <= '0;
      else if (install_i) valid_q[wr_index_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache between CPU fetch
// and IMem. Hits answer the cycle after the request; misses refill the whole
// line beat by beat from IMem, then answer.
//   clk, reset             : clock, async active-high reset
//   flush                  : one-cycle invalidate-all pulse (fence.i)
//   cpu_addr/cpu_valid     : fetch request, held until cpu_good
//   cpu_good/cpu_instr     : one-cycle response strobe and instruction
//   mem_addr/mem_valid     : refill word request, held until mem_good
//   mem_good/mem_instr     : IMem response strobe and data
//   hit_count/miss_count   : perf counters, present only with ICACHE_PERF_EN
module icache_direct
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_valid,
  output logic        cpu_good,
  output logic [31:0] cpu_instr,
  output logic [31:0] mem_addr,
  output logic        mem_valid,
  input  logic        mem_good,
  input  logic [31:0] mem_instr
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OW = offset_w(WORDS);
  localparam int IW = index_w(LINES);
  localparam int TW = tag_w(LINES, WORDS);

  state_e        state_q, state_d;
  logic [31:2]   addr_q, addr_d;
  logic [OW-1:0] beat_q, beat_d;
  logic [31:0]   instr_q, instr_d;
  logic          flush_pend_q, flush_pend_d;

  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [OW-1:0] lat_off;
  logic [IW-1:0] lat_idx;
  logic [TW-1:0] lat_tag;

  logic                   rd_valid;
  logic [TW-1:0]          rd_tag;
  logic [WORDS-1:0][31:0] rd_data;
  logic                   flush_all, wr_en, install;
  logic                   lookup_hit, take_req;
  logic                   unused_addr_bits;

  assign req_off = cpu_addr[2 +: OW];
  assign req_idx = cpu_addr[2+OW +: IW];
  assign req_tag = cpu_addr[2+OW+IW +: TW];
  assign lat_off = addr_q[2 +: OW];
  assign lat_idx = addr_q[2+OW +: IW];
  assign lat_tag = addr_q[2+OW+IW +: TW];
  assign unused_addr_bits = ^cpu_addr[1:0];

  icache_line_store #(.LINES(LINES), .WORDS(WORDS)) u_store (
    .clk           (clk),
    .reset         (reset),
    .flush_all_i   (flush_all),
    .rd_index_i    (req_idx),
    .rd_valid_o    (rd_valid),
    .rd_tag_o      (rd_tag),
    .rd_data_o     (rd_data),
    .wr_en_i       (wr_en),
    .wr_index_i    (lat_idx),
    .wr_word_i     (beat_q),
    .wr_data_i     (mem_instr),
    .install_i     (install),
    .install_tag_i (lat_tag)
  );

  assign lookup_hit = rd_valid && (rd_tag == req_tag);
  // A flush (live or pending) owns the IDLE cycle; the request waits one cycle.
  assign take_req   = (state_q == S_IDLE) && !(flush || flush_pend_q) && cpu_valid;
  assign cpu_instr  = instr_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    instr_d      = instr_q;
    flush_pend_d = flush_pend_q;
    flush_all    = 1'b0;
    wr_en        = 1'b0;
    install      = 1'b0;
    mem_valid    = 1'b0;
    mem_addr     = '0;
    cpu_good     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush || flush_pend_q) begin
          flush_all    = 1'b1;
          flush_pend_d = 1'b0;
        end else if (take_req) begin
          addr_d = cpu_addr[31:2];
          if (lookup_hit) begin
            instr_d = rd_data[req_off];
            state_d = S_RESP;
          end else begin
            beat_d  = '0;
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        mem_valid = 1'b1;
        mem_addr  = {addr_q[31:2+OW], beat_q, 2'b00};
        if (flush) flush_pend_d = 1'b1;
        if (mem_good) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == lat_off) instr_d = mem_instr;
          if (beat_q == OW'(WORDS-1)) begin
            install = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        // Requester may have withdrawn; the response is then dropped silently.
        cpu_good = cpu_valid;
        if (flush) flush_pend_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      instr_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      instr_q      <= instr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_q, miss_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (take_req) begin
      if (lookup_hit) hit_q  <= hit_q + 32'd1;
      else            miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct (default geometry 16 lines x 4 words).
// Counter checks are compiled in when ICACHE_PERF_EN is defined.
module tb_icache_direct;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] cpu_addr;
  logic        cpu_valid;
  logic        cpu_good;
  logic [31:0] cpu_instr;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic        mem_good;
  logic [31:0] mem_instr;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  icache_direct dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .cpu_addr  (cpu_addr),
    .cpu_valid (cpu_valid),
    .cpu_good  (cpu_good),
    .cpu_instr (cpu_instr),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_good  (mem_good),
    .mem_instr (mem_instr)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IMem contents: the line at 0x10 holds the test-plan words, everything
  // else reads back as 0xC000_0000 | address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h11;
      32'h14:  return 32'h22;
      32'h18:  return 32'h33;
      32'h1C:  return 32'h44;
      default: return 32'hC000_0000 | a;
    endcase
  endfunction

  task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  // Issue one fetch starting in an IDLE cycle (at a negedge). On a miss the
  // bench acts as zero-wait IMem. fb: beat at which flush pulses (-1 none);
  // db: beat at which cpu_valid is withdrawn (-1 none). Returns at the
  // negedge of the IDLE cycle after the response.
  task automatic fetch(input logic [31:0] a, input bit hit, input logic [31:0] ei,
                       input int fb, input int db);
    logic [31:0] wa;
    cpu_addr  = a;
    cpu_valid = 1'b1;
    @(negedge clk);
    check("mem_valid_after_req", 32'(mem_valid), 32'(!hit));
    if (!hit) begin
      for (int b = 0; b < 4; b++) begin
        if (b == db) cpu_valid = 1'b0;
        #1;
        wa = {a[31:4], 4'b0000} | (b << 2);
        check("refill_mem_addr", mem_addr, wa);
        check("no_good_in_refill", 32'(cpu_good), 32'd0);
        mem_good  = 1'b1;
        mem_instr = mem_word(wa);
        flush     = (b == fb);
        @(negedge clk);
        mem_good  = 1'b0;
        mem_instr = '0;
        flush     = 1'b0;
      end
    end
    #1;
    check("mem_valid_in_resp", 32'(mem_valid), 32'd0);
    check("cpu_good", 32'(cpu_good), 32'(db < 0));
    if (db < 0) check("cpu_instr", cpu_instr, ei);
    @(negedge clk);
    cpu_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    cpu_addr  = '0;
    cpu_valid = 1'b0;
    mem_good  = 1'b0;
    mem_instr = '0;
    @(negedge clk);
    #1;
    check("rst_cpu_good",  32'(cpu_good), 32'd0);
    check("rst_cpu_instr", cpu_instr, 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst_hits",   hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Cold miss, then hits in the same line (back to back).
    fetch(32'h10, 1'b0, 32'h11, -1, -1);
`ifdef ICACHE_PERF_EN
    check("miss_after_cold", miss_count, 32'd1);
`endif
    fetch(32'h18, 1'b1, 32'h33, -1, -1);
`ifdef ICACHE_PERF_EN
    check("hit_after_0x18", hit_count, 32'd1);
`endif

    // Stray mem_good while no refill is outstanding must do nothing.
    mem_good  = 1'b1;
    mem_instr = 32'hDEAD_BEEF;
    #1;
    check("stray_mem_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    mem_good  = 1'b0;
    mem_instr = '0;
    fetch(32'h14, 1'b1, 32'h22, -1, -1);

    // Conflict eviction at index 1.
    fetch(32'h110, 1'b0, 32'hC000_0110, -1, -1);
    fetch(32'h10,  1'b0, 32'h11, -1, -1);

    // Flush during refill: refill completes, pending flush eats next IDLE cycle.
    fetch(32'h20, 1'b0, 32'hC000_0020, 1, -1);
    cpu_addr  = 32'h20;
    cpu_valid = 1'b1;
    #1;
    check("flush_cycle_mem_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    #1;
    check("flush_cycle_no_good", 32'(cpu_good), 32'd0);
    check("flush_cycle_still_idle", 32'(mem_valid), 32'd0);
    fetch(32'h20, 1'b0, 32'hC000_0020, -1, -1);
    fetch(32'h10, 1'b0, 32'h11, -1, -1);

    // Requester withdraws mid-refill: line still installed.
    fetch(32'h30, 1'b0, 32'h0, -1, 2);
    fetch(32'h30, 1'b1, 32'hC000_0030, -1, -1);
`ifdef ICACHE_PERF_EN
    check("misses_before_reset", miss_count, 32'd7);
    check("hits_before_reset",   hit_count, 32'd3);
`endif

    // Reset in the middle of a refill.
    cpu_addr  = 32'h40;
    cpu_valid = 1'b1;
    @(negedge clk);
    check("pre_reset_mem_valid", 32'(mem_valid), 32'd1);
    for (int b = 0; b < 2; b++) begin
      mem_good  = 1'b1;
      mem_instr = mem_word(32'h40 + 32'(b * 4));
      @(negedge clk);
    end
    mem_good  = 1'b0;
    mem_instr = '0;
    reset     = 1'b1;
    #1;
    check("reset_mem_valid", 32'(mem_valid), 32'd0);
    check("reset_mem_addr",  mem_addr, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    cpu_valid = 1'b0;
    @(negedge clk);
`ifdef ICACHE_PERF_EN
    check("post_reset_misses", miss_count, 32'd0);
`endif
    fetch(32'h40, 1'b0, 32'hC000_0040, -1, -1);
    fetch(32'h30, 1'b0, 32'hC000_0030, -1, -1);
    fetch(32'h44, 1'b1, 32'hC000_0044, -1, -1);
`ifdef ICACHE_PERF_EN
    check("final_misses", miss_count, 32'd2);
    check("final_hits",   hit_count, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
